// File: rtl/pe_acc.sv
// Output accumulator behind one PE cell: sums k_len products with saturation and
// returns the result over a valid/ready handshake.
module pe_acc #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned K_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [K_W-1:0]   k_len,
    input  logic             c1_vld,
    input  logic [15:0]      c1_data,
    output logic             acc_vld,
    output logic [ACC_W-1:0] acc_data,
    output logic             acc_sat,
    input  logic             acc_rdy,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t             state_q, state_d;
    logic               busy_q;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               sat_q, sat_d;
    logic [K_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]   res_q, res_d;
    logic               rsat_q, rsat_d;
    logic               err_q, err_d;
    logic [ACC_W:0]     sum_ext;
    logic               last_prod;

    assign last_prod = c1_vld && (cnt_q == K_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start && (k_len != '0)) state_d = ACC;
            ACC:  if (last_prod)              state_d = HOLD;
            HOLD: if (acc_rdy)                state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // One extra carry bit detects overflow of the running sum.
    always_comb begin
        sum_d   = sum_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rsat_d  = rsat_q;
        err_d   = 1'b0;
        sum_ext = {1'b0, sum_q} + (ACC_W+1)'(c1_data);
        unique case (state_q)
            IDLE: begin
                err_d = c1_vld || (start && (k_len == '0));
                if (start && (k_len != '0)) begin
                    sum_d = '0;
                    sat_d = 1'b0;
                    cnt_d = k_len;
                end
            end
            ACC: begin
                err_d = start;
                if (c1_vld) begin
                    if (sat_q || sum_ext[ACC_W]) begin
                        sum_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        sum_d = sum_ext[ACC_W-1:0];
                    end
                    cnt_d = cnt_q - K_W'(1);
                    if (last_prod) begin
                        res_d  = sum_d;
                        rsat_d = sat_d;
                    end
                end
            end
            HOLD: err_d = start || c1_vld;
            default: err_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            sat_q  <= 1'b0;
            cnt_q  <= '0;
            res_q  <= '0;
            rsat_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            sat_q  <= sat_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            rsat_q <= rsat_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        acc_vld  = (state_q == HOLD);
        acc_data = res_q;
        acc_sat  = rsat_q;
        busy     = busy_q;
        err      = err_q;
    end

endmodule

// File: tb/tb_pe_acc.sv
// Directed bench for pe_acc: a 32-bit and a 17-bit instance share one stimulus stream.
module tb_pe_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  k_len;
    logic        c1_vld;
    logic [15:0] c1_data;
    logic        acc_rdy;

    logic        vld32, sat32, busy32, err32;
    logic [31:0] data32;
    logic        vld17, sat17, busy17, err17;
    logic [16:0] data17;

    int unsigned pass_cnt = 0;
    int unsigned fail_cnt = 0;
    int unsigned total    = 0;

    always #5 clk = ~clk;

    pe_acc #(.ACC_W(32), .K_W(8)) dut32 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .c1_vld(c1_vld), .c1_data(c1_data),
        .acc_vld(vld32), .acc_data(data32), .acc_sat(sat32),
        .acc_rdy(acc_rdy), .busy(busy32), .err(err32)
    );

    pe_acc #(.ACC_W(17), .K_W(8)) dut17 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .c1_vld(c1_vld), .c1_data(c1_data),
        .acc_vld(vld17), .acc_data(data17), .acc_sat(sat17),
        .acc_rdy(acc_rdy), .busy(busy17), .err(err17)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prod(input logic [15:0] d);
        c1_vld  = 1'b1;
        c1_data = d;
        tick();
        c1_vld  = 1'b0;
    endtask

    task automatic go(input logic [7:0] n);
        start = 1'b1;
        k_len = n;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0; c1_vld = 1'b0; c1_data = '0; acc_rdy = 1'b1;
        tick(); tick();
        chk("rst_vld",  vld32,  0);
        chk("rst_data", data32, 0);
        chk("rst_sat",  sat32,  0);
        chk("rst_busy", busy32, 0);
        chk("rst_err",  err32,  0);
        rst = 1'b0;
        tick();

        // 1: four back-to-back products
        go(8'd4);
        chk("t1_busy", busy32, 1);
        prod(16'd3); c1_vld = 1'b1; c1_data = 16'd5; tick();
        c1_data = 16'd7; tick();
        chk("t1_vld_early", vld32, 0);
        c1_data = 16'd9; tick();
        c1_vld = 1'b0;
        chk("t1_vld",  vld32,  1);
        chk("t1_data", data32, 24);
        chk("t1_sat",  sat32,  0);
        chk("t1_err",  err32,  0);
        tick();
        chk("t1_vld_drop", vld32,  0);
        chk("t1_idle",     busy32, 0);
        chk("t1_data_hold", data32, 24);

        // 2: gapped products, back-pressure, stray product while holding
        acc_rdy = 1'b0;
        go(8'd3);
        prod(16'd100); tick(); tick();
        prod(16'd200); tick(); tick();
        prod(16'd300);
        chk("t2_vld",  vld32,  1);
        chk("t2_data", data32, 600);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                c1_vld = 1'b1; c1_data = 16'd77;
            end
            tick();
            c1_vld = 1'b0;
            chk("t2_hold_vld",  vld32,  1);
            chk("t2_hold_data", data32, 600);
            chk("t2_hold_err",  err32,  (i == 1) ? 1 : 0);
        end
        acc_rdy = 1'b1;
        tick();
        chk("t2_vld_drop", vld32, 0);

        // 3: saturation in the 17-bit instance
        go(8'd3);
        prod(16'd65025); prod(16'd65025); prod(16'd65025);
        chk("t3_vld17",  vld17,  1);
        chk("t3_data17", data17, 131071);
        chk("t3_sat17",  sat17,  1);
        chk("t3_data32", data32, 195075);
        chk("t3_sat32",  sat32,  0);
        tick();

        // 4: zero-length start and stray product in IDLE
        go(8'd0);
        chk("t4_err_k0",  err32,  1);
        chk("t4_busy_k0", busy32, 0);
        tick();
        chk("t4_err_clr", err32, 0);
        prod(16'd500);
        chk("t4_err_idle_vld", err32,  1);
        chk("t4_busy_idle",    busy32, 0);
        chk("t4_vld_idle",     vld32,  0);
        tick();
        chk("t4_err_clr2", err32, 0);
        go(8'd2);
        prod(16'd10); prod(16'd20);
        chk("t4_data32", data32, 30);
        chk("t4_data17", data17, 30);
        tick();

        // 5: start during ACC, including one coinciding with a product
        go(8'd5);
        prod(16'd1); prod(16'd2);
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_err_start", err32,  1);
        chk("t5_busy",      busy32, 1);
        start = 1'b1; prod(16'd3); start = 1'b0;
        chk("t5_err_both", err32, 1);
        prod(16'd4);
        chk("t5_err_clr", err32, 0);
        chk("t5_vld_early", vld32, 0);
        prod(16'd5);
        chk("t5_vld",  vld32,  1);
        chk("t5_data", data32, 15);
        tick();

        // 6: asynchronous reset mid-ACC and mid-HOLD
        go(8'd3);
        prod(16'd7);
        rst = 1'b1; #1;
        chk("t6_acc_busy", busy32, 0);
        chk("t6_acc_data", data32, 0);
        rst = 1'b0;
        acc_rdy = 1'b0;
        tick();
        go(8'd1);
        prod(16'd9);
        chk("t6_hold_vld", vld32, 1);
        rst = 1'b1; #1;
        chk("t6_rst_vld",  vld32,  0);
        chk("t6_rst_data", data32, 0);
        chk("t6_rst_busy", busy32, 0);
        chk("t6_rst_sat",  sat17,  0);
        rst = 1'b0;
        acc_rdy = 1'b1;
        tick();
        go(8'd1);
        prod(16'd42);
        chk("t6_vld",  vld32,  1);
        chk("t6_data", data32, 42);
        chk("t6_sat",  sat32,  0);
        tick();
        chk("t6_done", busy32, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
